// File: rtl/gray_cnt_if.sv
// Control/status bundle between a gray_cnt and its driver.
// Master drives the controls; the counter (slave) returns Gray code and flags.
interface gray_cnt_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] gray_out;
    logic             tc;
    logic             step_err;

    modport master (
        output en, up_dn, load, load_bin,
        input  gray_out, tc, step_err
    );

    modport slave (
        input  en, up_dn, load, load_bin,
        output gray_out, tc, step_err
    );
endinterface

// File: rtl/gray_cnt.sv
// Up/down Gray counter: binary state plus registered Gray output and step checker.
// Define GRAY_CNT_SAT_EN to saturate at the terminal count instead of wrapping.
module gray_cnt #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic       clk,
    input  logic       rst,
    gray_cnt_if.slave  bus
);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             err_q, err_d;
    logic             tc;
    logic             step;

    always_comb begin
        tc = bus.up_dn ? (cnt_q == {WIDTH{1'b1}}) : (cnt_q == '0);
    end

    always_comb begin
`ifdef GRAY_CNT_SAT_EN
        step = bus.en && !bus.load && !tc;
`else
        step = bus.en && !bus.load;
`endif
    end

    always_comb begin
        cnt_d  = cnt_q;
        gray_d = gray_q;
        err_d  = err_q;
        if (bus.load) begin
            cnt_d  = bus.load_bin;
            gray_d = bus.load_bin ^ (bus.load_bin >> 1);
        end else if (step) begin
            cnt_d  = bus.up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
            gray_d = cnt_d ^ (cnt_d >> 1);
            // Any step must flip exactly one output bit
            if ($countones(gray_d ^ gray_q) != 1)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            err_q  <= err_d;
        end
    end

    assign bus.gray_out = gray_q;
    assign bus.tc       = tc;
    assign bus.step_err = err_q;
endmodule
